memory_controller: RTL and testbench

MEMORY_CONTROLLER -- requirements
Module: memory_controller

---
 rtl/memory_controller.sv | 169 ++++++++++++++++
 tb/tb_memory_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_controller.sv
`timescale 1ns/1ps
// memory_controller: byte-serial RAM sequencer shared by instruction fetch and load/store.
// Optional MEMCTRL_IO_STALL_EN holds store bytes aimed at the UART window while its buffer is full.
module memory_controller #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clockIn,
  input  logic                  resetIn,
  input  logic                  readyIn,
  input  logic                  clearIn,
  input  logic                  ifFlag,
  input  logic [ADDR_WIDTH-1:0] ifAddr,
  output logic [31:0]           ifData,
  output logic                  ifOkFlag,
  input  logic                  lsbFlag,
  input  logic [2:0]            lsbOp,
  input  logic [ADDR_WIDTH-1:0] lsbAddr,
  input  logic [31:0]           lsbDataIn,
  output logic [31:0]           lsbDataOut,
  output logic                  lsbOkFlag,
  input  logic [7:0]            memIn,
  output logic [7:0]            memOut,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memWr,
  input  logic                  ioBufferFull
);
  localparam int unsigned CNT_WIDTH = 3;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

  state_t                state, stateNext;
  logic [CNT_WIDTH-1:0]  cnt, cntNext, len, lenNext;
  logic [ADDR_WIDTH-1:0] addrNext;
  logic [31:0]           storeData, storeDataNext, buffer, bufferNext, bufMerged;
  logic [31:0]           ifDataNext, lsbDataNext;
  logic [7:0]            memOutNext;
  logic                  captured, capturedNext, ifOkNext, lsbOkNext;
  logic                  capturing, ioStall, writeFire;
  logic [1:0]            slot, nextSlot;

`ifdef MEMCTRL_IO_STALL_EN
  assign ioStall = (memAddr[17:16] == 2'b11) && ioBufferFull;
`else
  logic unusedIoBufferFull;
  assign unusedIoBufferFull = ioBufferFull;
  assign ioStall = 1'b0;
`endif

  // A write only leaves the block on an enabled, unstalled store cycle
  assign writeFire = (state == STORE) && readyIn && !ioStall;
  assign memWr     = writeFire;

  assign slot     = 2'(cnt - 3'd1);
  assign nextSlot = 2'(cnt + 3'd1);

  // memIn carries byte cnt-1; a stall grabs it once so the re-presented byte is not taken twice
  assign capturing = ((state == FETCH) || (state == LOAD)) && (cnt != '0) && !captured;

  always_comb begin
    bufMerged = buffer;
    if (capturing) bufMerged[{slot, 3'b000} +: 8] = memIn;
  end

  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    lenNext       = len;
    addrNext      = memAddr;
    storeDataNext = storeData;
    bufferNext    = buffer;
    capturedNext  = captured;
    memOutNext    = memOut;
    ifOkNext      = 1'b0;
    lsbOkNext     = 1'b0;
    ifDataNext    = ifData;
    lsbDataNext   = lsbDataOut;
    case (state)
      IDLE: begin
        if (readyIn && !clearIn && !ifOkFlag && !lsbOkFlag && (lsbFlag || ifFlag)) begin
          cntNext      = '0;
          bufferNext   = '0;
          capturedNext = 1'b0;
          if (lsbFlag) begin
            stateNext     = lsbOp[2] ? STORE : LOAD;
            lenNext       = (lsbOp[1:0] == 2'b00) ? 3'd1 : (lsbOp[1:0] == 2'b01) ? 3'd2 : 3'd4;
            addrNext      = lsbAddr;
            storeDataNext = lsbDataIn;
            memOutNext    = lsbOp[2] ? lsbDataIn[7:0] : 8'd0;
          end else begin
            stateNext = FETCH;
            lenNext   = 3'd4;
            addrNext  = ifAddr;
          end
        end
      end
      FETCH, LOAD: begin
        bufferNext = bufMerged;
        if (!readyIn) begin
          capturedNext = captured | capturing;
        end else if (clearIn) begin
          stateNext = IDLE;
          cntNext   = '0;
          addrNext  = '0;
        end else if (cnt == len) begin
          stateNext = IDLE;
          cntNext   = '0;
          addrNext  = '0;
          if (state == FETCH) begin
            ifOkNext   = 1'b1;
            ifDataNext = bufMerged;
          end else begin
            lsbOkNext   = 1'b1;
            lsbDataNext = bufMerged;
          end
        end else begin
          cntNext      = cnt + 3'd1;
          capturedNext = 1'b0;
          if (3'(cnt + 3'd1) < len) addrNext = memAddr + ADDR_WIDTH'(1);
        end
      end
      STORE: begin
        if (writeFire) begin
          if (cnt == 3'(len - 3'd1)) begin
            stateNext  = IDLE;
            cntNext    = '0;
            addrNext   = '0;
            memOutNext = '0;
            lsbOkNext  = 1'b1;
          end else begin
            cntNext    = cnt + 3'd1;
            addrNext   = memAddr + ADDR_WIDTH'(1);
            memOutNext = storeData[{nextSlot, 3'b000} +: 8];
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      state      <= IDLE;
      cnt        <= '0;
      len        <= '0;
      memAddr    <= '0;
      storeData  <= '0;
      buffer     <= '0;
      captured   <= 1'b0;
      memOut     <= '0;
      ifOkFlag   <= 1'b0;
      lsbOkFlag  <= 1'b0;
      ifData     <= '0;
      lsbDataOut <= '0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      len        <= lenNext;
      memAddr    <= addrNext;
      storeData  <= storeDataNext;
      buffer     <= bufferNext;
      captured   <= capturedNext;
      memOut     <= memOutNext;
      ifOkFlag   <= ifOkNext;
      lsbOkFlag  <= lsbOkNext;
      ifData     <= ifDataNext;
      lsbDataOut <= lsbDataNext;
    end
  end
endmodule

// File: tb/tb_memory_controller.sv
`timescale 1ns/1ps
// Self-checking bench for memory_controller: transaction-level model plus directed literal scenarios.
module tb_memory_controller;
  localparam int unsigned AW = 32;

  logic          clockIn = 1'b0;
  logic          resetIn = 1'b1;
  logic          readyIn = 1'b1, clearIn = 1'b0, ifFlag = 1'b0, lsbFlag = 1'b0, ioBufferFull = 1'b0;
  logic [AW-1:0] ifAddr = '0, lsbAddr = '0, memAddr;
  logic [2:0]    lsbOp = '0;
  logic [31:0]   lsbDataIn = '0, ifData, lsbDataOut;
  logic          ifOkFlag, lsbOkFlag, memWr;
  logic [7:0]    memIn = '0, memOut;

  logic [7:0]    ram [0:4095];
  int            nChecks = 0, nFails = 0;
  logic          wrSeen [0:63];
  logic [7:0]    wrByte [0:63];

  memory_controller #(.ADDR_WIDTH(AW)) dut (
    .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn), .clearIn(clearIn),
    .ifFlag(ifFlag), .ifAddr(ifAddr), .ifData(ifData), .ifOkFlag(ifOkFlag),
    .lsbFlag(lsbFlag), .lsbOp(lsbOp), .lsbAddr(lsbAddr), .lsbDataIn(lsbDataIn),
    .lsbDataOut(lsbDataOut), .lsbOkFlag(lsbOkFlag),
    .memIn(memIn), .memOut(memOut), .memAddr(memAddr), .memWr(memWr),
    .ioBufferFull(ioBufferFull)
  );

  always #5 clockIn = ~clockIn;

  // External RAM: one-cycle read latency, low 12 address bits decoded
  always @(posedge clockIn) begin
    memIn <= ram[memAddr[11:0]];
    if (memWr) ram[memAddr[11:0]] <= memOut;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: progress counts enabled edges since accept
  bit          mBusy = 1'b0, expIfOk = 1'b0, expLsbOk = 1'b0, expLsbIsLoad = 1'b0;
  int          mKind = 0, mN = 0, mP = 0;
  logic [31:0] mBase = '0, mSData = '0, mResult = '0, expIfData = '0, expLsbData = '0;

  function automatic bit ioStallNow();
    logic [31:0] a;
    a = mBase + 32'(mP);
`ifdef MEMCTRL_IO_STALL_EN
    return (a[17:16] == 2'b11) && ioBufferFull;
`else
    return (a[17:16] == 2'b11) && 1'b0;
`endif
  endfunction

  always @(posedge clockIn) begin
    bit okNow;
    okNow    = expIfOk | expLsbOk;
    expIfOk  = 1'b0;
    expLsbOk = 1'b0;
    if (resetIn) begin
      mBusy = 1'b0;
    end else if (mBusy) begin
      if (readyIn) begin
        if (mKind == 2) begin
          if (!ioStallNow()) begin
            mP++;
            if (mP == mN) begin mBusy = 1'b0; expLsbOk = 1'b1; expLsbIsLoad = 1'b0; end
          end
        end else if (clearIn) begin
          mBusy = 1'b0;
        end else begin
          mP++;
          if (mP == mN + 1) begin
            mBusy = 1'b0;
            if (mKind == 0) begin expIfOk = 1'b1; expIfData = mResult; end
            else begin expLsbOk = 1'b1; expLsbIsLoad = 1'b1; expLsbData = mResult; end
          end
        end
      end
    end else if (readyIn && !clearIn && !okNow && (lsbFlag || ifFlag)) begin
      mBusy = 1'b1;
      mP    = 0;
      if (lsbFlag) begin
        mKind  = lsbOp[2] ? 2 : 1;
        mN     = (lsbOp[1:0] == 2'b00) ? 1 : (lsbOp[1:0] == 2'b01) ? 2 : 4;
        mBase  = lsbAddr;
        mSData = lsbDataIn;
      end else begin
        mKind = 0;
        mN    = 4;
        mBase = ifAddr;
      end
      mResult = '0;
      if (mKind != 2)
        for (int i = 0; i < mN; i++) mResult[8*i +: 8] = ram[12'(mBase + 32'(i))];
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle after inputs settle
  always @(negedge clockIn) begin
    bit expWr;
    #2;
    if (resetIn) begin
      chk("rst_ifOk", 32'(ifOkFlag), 32'd0);
      chk("rst_lsbOk", 32'(lsbOkFlag), 32'd0);
      chk("rst_memWr", 32'(memWr), 32'd0);
      chk("rst_memAddr", memAddr, 32'd0);
      chk("rst_memOut", 32'(memOut), 32'd0);
      chk("rst_ifData", ifData, 32'd0);
      chk("rst_lsbData", lsbDataOut, 32'd0);
    end else begin
      chk("ifOk", 32'(ifOkFlag), 32'(expIfOk));
      chk("lsbOk", 32'(lsbOkFlag), 32'(expLsbOk));
      if (expIfOk) chk("ifData", ifData, expIfData);
      if (expLsbOk && expLsbIsLoad) chk("lsbData", lsbDataOut, expLsbData);
      expWr = mBusy && (mKind == 2) && readyIn && !ioStallNow();
      chk("memWr", 32'(memWr), 32'(expWr));
      if (!mBusy) chk("memAddr_idle", memAddr, 32'd0);
      else if (mP < mN) chk("memAddr", memAddr, mBase + 32'(mP));
      if (expWr) chk("memOut", 32'(memOut), 32'(mSData[8*mP +: 8]));
    end
  end

  task automatic runWatch(input int maxc, input bit holdIf, input int clrA, input int clrB,
                          input int rdyA, input int rdyB, input int ioA, input int ioB,
                          output int okIfC, output int okLsbC,
                          output logic [31:0] ifD, output logic [31:0] lsbD);
    okIfC = -1; okLsbC = -1; ifD = '0; lsbD = '0;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clockIn);
      if (c == 1) lsbFlag = 1'b0;
      if (c == 1 && !holdIf) ifFlag = 1'b0;
      clearIn      = (c >= clrA && c <= clrB);
      readyIn      = !(c >= rdyA && c <= rdyB);
      ioBufferFull = (c >= ioA && c <= ioB);
      #2;
      wrSeen[c] = memWr;
      wrByte[c] = memOut;
      if (ifOkFlag && okIfC < 0) begin okIfC = c; ifD = ifData; ifFlag = 1'b0; end
      if (lsbOkFlag && okLsbC < 0) begin okLsbC = c; lsbD = lsbDataOut; end
    end
    clearIn = 1'b0; readyIn = 1'b1; ioBufferFull = 1'b0;
  endtask

  task automatic reqLsb(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    @(negedge clockIn);
    lsbFlag = 1'b1; lsbOp = op; lsbAddr = a; lsbDataIn = d;
  endtask

  task automatic reqIf(input logic [31:0] a);
    @(negedge clockIn);
    ifFlag = 1'b1; ifAddr = a;
  endtask

  initial begin
    int okI, okL, firstWr;
    logic [31:0] dI, dL;
    logic [7:0] beBytes [0:3];
    logic [1:0] sz;
    beBytes[0] = 8'hEF; beBytes[1] = 8'hBE; beBytes[2] = 8'hAD; beBytes[3] = 8'hDE;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'hA0; ram[12'h103] = 8'h00;
    repeat (3) @(negedge clockIn);
    resetIn = 1'b0;

    // Fetch of a known instruction word
    reqIf(32'h100);
    runWatch(10, 0, 0, 0, 0, 0, 0, 0, okI, okL, dI, dL);
    chk("fetch_ok_cycle", 32'(okI), 32'd6);
    chk("fetch_data", dI, 32'h00A00513);
    chk("fetch_no_lsbOk", 32'(okL), 32'(-1));

    // Simultaneous store and fetch: store wins, fetch follows
    @(negedge clockIn);
    lsbFlag = 1'b1; lsbOp = 3'b111; lsbAddr = 32'h200; lsbDataIn = 32'hDEADBEEF;
    ifFlag = 1'b1; ifAddr = 32'h100;
    runWatch(16, 1, 0, 0, 0, 0, 0, 0, okI, okL, dI, dL);
    for (int c = 1; c <= 4; c++) begin
      chk("arb_memWr", 32'(wrSeen[c]), 32'd1);
      chk("arb_byte", 32'(wrByte[c]), 32'(beBytes[c-1]));
    end
    chk("arb_memWr_c5", 32'(wrSeen[5]), 32'd0);
    chk("arb_lsbOk_cycle", 32'(okL), 32'd5);
    chk("arb_fetch_ok_cycle", 32'(okI), 32'd12);
    chk("arb_fetch_data", dI, 32'h00A00513);
    chk("arb_ram", {ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]}, 32'hDEADBEEF);

    // Half-word load, zero-extended
    ram[12'h300] = 8'h80; ram[12'h301] = 8'hFF;
    reqLsb(3'b001, 32'h300, 32'h0);
    runWatch(8, 0, 0, 0, 0, 0, 0, 0, okI, okL, dI, dL);
    chk("half_ok_cycle", 32'(okL), 32'd4);
    chk("half_data", dL, 32'h0000FF80);

    // Flush a fetch mid-flight, then flush during a store
    reqIf(32'h100);
    runWatch(10, 0, 3, 3, 0, 0, 0, 0, okI, okL, dI, dL);
    chk("flush_fetch_no_ok", 32'(okI), 32'(-1));
    reqLsb(3'b111, 32'h210, 32'h12345678);
    runWatch(8, 0, 2, 3, 0, 0, 0, 0, okI, okL, dI, dL);
    chk("flush_store_ok_cycle", 32'(okL), 32'd5);
    chk("flush_store_ram", {ram[12'h213], ram[12'h212], ram[12'h211], ram[12'h210]}, 32'h12345678);

    // Three-cycle readyIn drop mid word load
    ram[12'h400] = 8'h11; ram[12'h401] = 8'h22; ram[12'h402] = 8'h33; ram[12'h403] = 8'h44;
    reqLsb(3'b011, 32'h400, 32'h0);
    runWatch(14, 0, 0, 0, 2, 4, 0, 0, okI, okL, dI, dL);
    chk("ready_ok_cycle", 32'(okL), 32'd9);
    chk("ready_data", dL, 32'h44332211);

    // Byte store into the UART window with the buffer full for five cycles
    reqLsb(3'b100, 32'h30000, 32'h000000A5);
    runWatch(12, 0, 0, 0, 0, 0, 1, 5, okI, okL, dI, dL);
    firstWr = -1;
    for (int c = 12; c >= 1; c--) if (wrSeen[c]) firstWr = c;
`ifdef MEMCTRL_IO_STALL_EN
    chk("io_first_wr", 32'(firstWr), 32'd6);
    chk("io_ok_cycle", 32'(okL), 32'd7);
`else
    chk("io_first_wr", 32'(firstWr), 32'd1);
    chk("io_ok_cycle", 32'(okL), 32'd2);
`endif
    chk("io_ram", 32'(ram[12'h000]), 32'h000000A5);

    // Word load that wraps past the top of the address space
    ram[12'hFFE] = 8'h01; ram[12'hFFF] = 8'h02; ram[12'h000] = 8'h03; ram[12'h001] = 8'h04;
    reqLsb(3'b011, 32'hFFFFFFFE, 32'h0);
    runWatch(8, 0, 0, 0, 0, 0, 0, 0, okI, okL, dI, dL);
    chk("wrap_data", dL, 32'h04030201);

    // Reset mid-load abandons the transfer
    reqLsb(3'b011, 32'h100, 32'h0);
    runWatch(2, 0, 0, 0, 0, 0, 0, 0, okI, okL, dI, dL);
    @(negedge clockIn);
    resetIn = 1'b1;
    #1;
    chk("midrst_memAddr", memAddr, 32'd0);
    chk("midrst_memWr", 32'(memWr), 32'd0);
    @(negedge clockIn);
    resetIn = 1'b0;
    runWatch(8, 0, 0, 0, 0, 0, 0, 0, okI, okL, dI, dL);
    chk("midrst_no_ok", 32'(okL), 32'(-1));

    // clearIn in IDLE blocks acceptance
    @(negedge clockIn);
    ifFlag = 1'b1; ifAddr = 32'h100; clearIn = 1'b1;
    runWatch(8, 0, 0, 0, 0, 0, 0, 0, okI, okL, dI, dL);
    chk("idle_clear_no_ok", 32'(okI), 32'(-1));

    // Random traffic checked cycle by cycle against the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clockIn);
      resetIn      = ($urandom_range(0, 599) == 0);
      readyIn      = ($urandom_range(0, 9) != 0);
      clearIn      = ($urandom_range(0, 19) == 0);
      ioBufferFull = ($urandom_range(0, 2) == 0);
      lsbFlag      = ($urandom_range(0, 2) == 0);
      ifFlag       = ($urandom_range(0, 1) == 0);
      case ($urandom_range(0, 2))
        0:       sz = 2'b00;
        1:       sz = 2'b01;
        default: sz = 2'b11;
      endcase
      lsbOp     = {1'($urandom_range(0, 1)), sz};
      lsbAddr   = ($urandom_range(0, 3) == 0) ? {20'hFFFFF, 12'($urandom)} : 32'($urandom_range(0, 4095));
      ifAddr    = ($urandom_range(0, 3) == 0) ? {20'hFFFFF, 12'($urandom)} : 32'($urandom_range(0, 4095));
      lsbDataIn = $urandom;
    end
    @(negedge clockIn);
    resetIn = 1'b0; readyIn = 1'b1; clearIn = 1'b0; ioBufferFull = 1'b0; lsbFlag = 1'b0; ifFlag = 1'b0;
    repeat (20) @(negedge clockIn);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
